coram_instream_dma: RTL and testbench

CORAM_INSTREAM_DMA -- requirements
Module: coram_instream_dma

---
 rtl/coram_instream_dma.sv | 144 ++++++++++++++
 tb/tb_coram_instream_dma.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coram_instream_dma.sv
// rtl/coram_instream_dma.sv - streams an external word region into a BRAM FIFO using single-outstanding read bursts
// Bursts are issued only once the FIFO has room for the whole burst, so the data path needs no backpressure.
module coram_instream_dma #(
   parameter int CORAM_DATA_WIDTH = 32,
   parameter int CORAM_ADDR_LEN   = 10,
   parameter int EXT_ADDR_WIDTH   = 32,
   parameter int MAX_BURST        = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        REQ_VALID,
   output logic                        REQ_READY,
   input  logic [EXT_ADDR_WIDTH-1:0]   REQ_ADDR,
   input  logic [15:0]                 REQ_SIZE,
   output logic                        RD_VALID,
   input  logic                        RD_READY,
   output logic [EXT_ADDR_WIDTH-1:0]   RD_ADDR,
   output logic [7:0]                  RD_LEN,
   input  logic                        RD_DVALID,
   input  logic [CORAM_DATA_WIDTH-1:0] RD_DATA,
   output logic [CORAM_DATA_WIDTH-1:0] Q,
   input  logic                        DEQ,
   output logic                        EMPTY,
   output logic                        ALM_EMPTY,
   output logic                        BUSY,
   output logic                        DONE
);
   localparam int DEPTH = 2**CORAM_ADDR_LEN;
   localparam int CW    = CORAM_ADDR_LEN + 1;
   localparam logic [CW-1:0]             CNT_ONE = CW'(1);
   localparam logic [CORAM_ADDR_LEN-1:0] PTR_ONE = CORAM_ADDR_LEN'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;
   state_t r_state, w_state_nxt;

   logic [EXT_ADDR_WIDTH-1:0]   r_cur_addr;
   logic [15:0]                 r_remaining;
   logic [7:0]                  r_burst_len;
   logic [7:0]                  r_beats_left;
   logic                        r_done;
   logic [CORAM_DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [CORAM_ADDR_LEN-1:0]   r_wptr, r_rptr;
   logic [CW-1:0]               r_count, w_count_nxt;
   logic [CORAM_DATA_WIDTH-1:0] r_q;
   logic                        r_empty, r_alm_empty;

   logic          w_req_fire, w_rd_fire, w_wr, w_pop, w_last_beat;
   logic [15:0]   w_burst_len;
   logic [CW-1:0] w_free;

   assign w_burst_len = (r_remaining < 16'(MAX_BURST)) ? r_remaining : 16'(MAX_BURST);
   assign w_free      = CW'(DEPTH) - r_count;

   assign REQ_READY   = (r_state == IDLE);
   assign RD_VALID    = (r_state == ISSUE) && (32'(w_free) >= 32'(w_burst_len));
   assign RD_ADDR     = r_cur_addr;
   assign RD_LEN      = w_burst_len[7:0];
   assign BUSY        = (r_state == ISSUE) || (r_state == DATA);
   assign DONE        = r_done;
   assign Q           = r_q;
   assign EMPTY       = r_empty;
   assign ALM_EMPTY   = r_alm_empty;

   assign w_req_fire  = REQ_VALID && REQ_READY;
   assign w_rd_fire   = RD_VALID && RD_READY;
   assign w_wr        = (r_state == DATA) && RD_DVALID;
   assign w_last_beat = w_wr && (r_beats_left == 8'd1);
   assign w_pop       = DEQ && (r_count != '0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_req_fire && (REQ_SIZE != 16'd0)) w_state_nxt = ISSUE;
         ISSUE:   if (w_rd_fire) w_state_nxt = DATA;
         DATA:    if (w_last_beat) w_state_nxt = (r_remaining == 16'd1) ? IDLE : ISSUE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cur_addr   <= '0;
         r_remaining  <= '0;
         r_burst_len  <= '0;
         r_beats_left <= '0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_req_fire) begin
            r_cur_addr  <= REQ_ADDR;
            r_remaining <= REQ_SIZE;
            r_done      <= (REQ_SIZE == 16'd0);
         end
         if (w_rd_fire) begin
            r_burst_len  <= RD_LEN;
            r_beats_left <= RD_LEN;
         end
         if (w_wr) begin
            r_remaining  <= r_remaining - 16'd1;
            r_beats_left <= r_beats_left - 8'd1;
         end
         // remaining still holds the pre-decrement value on the final beat
         if (w_last_beat) begin
            r_cur_addr <= r_cur_addr + EXT_ADDR_WIDTH'(r_burst_len);
            r_done     <= (r_remaining == 16'd1);
         end
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr && !w_pop)      w_count_nxt = r_count + CNT_ONE;
      else if (!w_wr && w_pop) w_count_nxt = r_count - CNT_ONE;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_q         <= '0;
         r_empty     <= 1'b1;
         r_alm_empty <= 1'b1;
      end else begin
         if (w_wr) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
            r_q    <= r_mem[r_rptr];
         end
         r_count     <= w_count_nxt;
         r_empty     <= (w_count_nxt == '0);
         r_alm_empty <= (w_count_nxt <= CNT_ONE);
      end
   end

   always_ff @(posedge CLK) begin
      if (w_wr) r_mem[r_wptr] <= RD_DATA;
   end
endmodule

// File: tb/tb_coram_instream_dma.sv
// tb/tb_coram_instream_dma.sv - randomized bench against a queue-based transfer/FIFO reference model
module tb_coram_instream_dma;
   localparam int DW    = 32;
   localparam int AL    = 4;
   localparam int AW    = 32;
   localparam int MB    = 16;
   localparam int DEPTH = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          REQ_VALID = 1'b0;
   logic          REQ_READY;
   logic [AW-1:0] REQ_ADDR = '0;
   logic [15:0]   REQ_SIZE = '0;
   logic          RD_VALID;
   logic          RD_READY = 1'b0;
   logic [AW-1:0] RD_ADDR;
   logic [7:0]    RD_LEN;
   logic          RD_DVALID = 1'b0;
   logic [DW-1:0] RD_DATA = '0;
   logic [DW-1:0] Q;
   logic          DEQ = 1'b0;
   logic          EMPTY, ALM_EMPTY, BUSY, DONE;

   coram_instream_dma #(
      .CORAM_DATA_WIDTH(DW), .CORAM_ADDR_LEN(AL), .EXT_ADDR_WIDTH(AW), .MAX_BURST(MB)
   ) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR), .REQ_SIZE(REQ_SIZE),
      .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN),
      .RD_DVALID(RD_DVALID), .RD_DATA(RD_DATA),
      .Q(Q), .DEQ(DEQ), .EMPTY(EMPTY), .ALM_EMPTY(ALM_EMPTY), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: FIFO contents, planned bursts, and the transfer's progress
   logic [DW-1:0] m_fifo[$];
   logic [DW-1:0] m_q = '0;
   logic [AW-1:0] m_plan_addr[$];
   int            m_plan_len[$];
   logic [AW-1:0] m_acc_addr[$];
   int            m_acc_len[$];
   logic [AW-1:0] m_beat_addr = '0;
   int            m_beats_left = 0;
   bit            m_active = 0, m_outstanding = 0, m_done = 0;

   int deq_pct = 0, rdy_pct = 100, beat_pct = 100, stray_pct = 0, rdy_hold_low = 0;
   bit deq_on_one = 0;
   bit req_pending = 0;
   logic [AW-1:0] req_addr = '0;
   logic [15:0]   req_size = '0;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic plan(input logic [AW-1:0] a, input int size);
      int rem;
      int l;
      logic [AW-1:0] addr;
      rem = size;
      addr = a;
      while (rem > 0) begin
         l = (rem < MB) ? rem : MB;
         m_plan_addr.push_back(addr);
         m_plan_len.push_back(l);
         addr = addr + AW'(l);
         rem -= l;
      end
   endtask

   task automatic cycle();
      bit exp_rdv;
      bit was_idle;
      @(negedge CLK);
      exp_rdv = m_active && !m_outstanding && (m_plan_len.size() > 0) &&
                ((DEPTH - m_fifo.size()) >= m_plan_len[0]);
      check_eq("rd_valid", RD_VALID, exp_rdv);
      if (RD_VALID && exp_rdv) begin
         check_eq("rd_addr", RD_ADDR, m_plan_addr[0]);
         check_eq("rd_len", RD_LEN, m_plan_len[0]);
      end
      check_eq("q", Q, m_q);
      check_eq("empty", EMPTY, m_fifo.size() == 0);
      check_eq("alm_empty", ALM_EMPTY, m_fifo.size() <= 1);
      check_eq("busy", BUSY, m_active);
      check_eq("req_ready", REQ_READY, !m_active);
      check_eq("done", DONE, m_done);
      m_done = 0;
      was_idle = !m_active;

      REQ_VALID = req_pending;
      REQ_ADDR  = req_addr;
      REQ_SIZE  = req_size;
      if (rdy_hold_low > 0) begin
         RD_READY = 1'b0;
         if (RD_VALID) rdy_hold_low--;
      end else begin
         RD_READY = ($urandom_range(99) < rdy_pct);
      end
      if (m_outstanding) RD_DVALID = ($urandom_range(99) < beat_pct);
      else               RD_DVALID = ($urandom_range(99) < stray_pct);
      RD_DATA = (m_outstanding && RD_DVALID) ? mem_word(m_beat_addr) : DW'($urandom);
      DEQ = deq_on_one ? (m_fifo.size() == 1) : ($urandom_range(99) < deq_pct);

      // effects of the coming edge: pop sees pre-edge occupancy, then the beat lands
      if (DEQ && m_fifo.size() > 0) m_q = m_fifo.pop_front();
      if (m_outstanding && RD_DVALID) begin
         m_fifo.push_back(mem_word(m_beat_addr));
         m_beat_addr++;
         m_beats_left--;
         if (m_beats_left == 0) begin
            m_outstanding = 0;
            if (m_plan_len.size() == 0) begin
               m_active = 0;
               m_done = 1;
            end
         end
      end
      if (exp_rdv && RD_READY) begin
         m_beat_addr  = m_plan_addr.pop_front();
         m_beats_left = m_plan_len.pop_front();
         m_acc_addr.push_back(m_beat_addr);
         m_acc_len.push_back(m_beats_left);
         m_outstanding = 1;
      end
      if (req_pending && was_idle) begin
         req_pending = 0;
         if (req_size == 16'd0) m_done = 1;
         else begin
            m_active = 1;
            plan(req_addr, int'(req_size));
         end
      end
   endtask

   task automatic start(input logic [AW-1:0] a, input logic [15:0] s);
      req_addr = a;
      req_size = s;
      req_pending = 1;
      m_acc_addr.delete();
      m_acc_len.delete();
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = budget;
      while ((m_active || req_pending) && n > 0) begin
         cycle();
         n--;
      end
      check_eq("idle_timeout", n > 0, 1);
   endtask

   task automatic drain();
      int n;
      deq_on_one = 0;
      deq_pct = 100;
      n = 200;
      while (m_fifo.size() > 0 && n > 0) begin
         cycle();
         n--;
      end
      check_eq("drain_timeout", n > 0, 1);
      repeat (3) cycle();
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0;
      REQ_VALID = 1'b0;
      RD_READY = 1'b0;
      RD_DVALID = 1'b0;
      DEQ = 1'b0;
      m_fifo.delete();
      m_plan_addr.delete();
      m_plan_len.delete();
      m_q = '0;
      m_active = 0;
      m_outstanding = 0;
      m_done = 0;
      req_pending = 0;
      #1;
      check_eq("rst_q", Q, 0);
      check_eq("rst_empty", EMPTY, 1);
      check_eq("rst_alm_empty", ALM_EMPTY, 1);
      check_eq("rst_rd_valid", RD_VALID, 0);
      check_eq("rst_busy", BUSY, 0);
      check_eq("rst_done", DONE, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      int n;
      do_reset();

      // 40 words from 0x100 in 16/16/8 bursts
      deq_pct = 50;
      start(32'h100, 16'd40);
      wait_idle(600);
      check_eq("s1_nbursts", m_acc_len.size(), 3);
      if (m_acc_len.size() == 3) begin
         check_eq("s1_b0_addr", m_acc_addr[0], 32'h100);
         check_eq("s1_b0_len", m_acc_len[0], 16);
         check_eq("s1_b1_addr", m_acc_addr[1], 32'h110);
         check_eq("s1_b1_len", m_acc_len[1], 16);
         check_eq("s1_b2_addr", m_acc_addr[2], 32'h120);
         check_eq("s1_b2_len", m_acc_len[2], 8);
      end
      drain();

      // zero-length request
      start(32'h500, 16'd0);
      repeat (6) cycle();
      check_eq("s2_nbursts", m_acc_len.size(), 0);

      // no consumer: second burst must wait for 16 pops
      deq_pct = 0;
      start(32'h2000, 16'd32);
      repeat (40) cycle();
      check_eq("s3_nbursts_full", m_acc_len.size(), 1);
      check_eq("s3_full_empty", EMPTY, 0);
      deq_pct = 100;
      wait_idle(400);
      check_eq("s3_nbursts", m_acc_len.size(), 2);
      drain();

      // command held off by RD_READY low for 5 valid cycles
      deq_pct = 0;
      rdy_hold_low = 5;
      start(32'h3000, 16'd8);
      wait_idle(200);
      check_eq("s4_nbursts", m_acc_len.size(), 1);
      check_eq("s4_hold_used", rdy_hold_low, 0);
      drain();

      // write and pop together at one word, then DEQ on empty
      deq_on_one = 1;
      beat_pct = 100;
      start(32'h4000, 16'd5);
      wait_idle(200);
      drain();
      repeat (4) cycle();

      // reset mid-burst, then stray beats
      deq_pct = 0;
      beat_pct = 60;
      start(32'h5000, 16'd40);
      n = 300;
      while (!(m_outstanding && m_fifo.size() >= 3) && n > 0) begin
         cycle();
         n--;
      end
      check_eq("s6_reach_data", n > 0, 1);
      do_reset();
      stray_pct = 100;
      repeat (10) cycle();
      check_eq("s6_empty_after", EMPTY, 1);
      stray_pct = 0;

      // randomized transfers, some wrapping the address space
      for (int t = 0; t < 30; t++) begin
         deq_pct   = $urandom_range(20, 100);
         rdy_pct   = $urandom_range(30, 100);
         beat_pct  = $urandom_range(30, 100);
         stray_pct = $urandom_range(0, 50);
         if ($urandom_range(3) == 0) start(32'hFFFF_FFF0 + AW'($urandom_range(15)), 16'($urandom_range(0, 50)));
         else                        start(AW'($urandom), 16'($urandom_range(0, 50)));
         wait_idle(3000);
         drain();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
